// File: rtl/encoder_pkg.sv
// Shared constants and state type for the event encoder.
package encoder_pkg;
  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: index of the highest set bit, plus a
// flag telling whether any bit is set at all.
module prio_enc
  import encoder_pkg::*;
(
  input  logic [N-1:0] in_vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // NOTE: every output gets a default before the loop, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Ascending scan: the last hit wins, giving the highest index.
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        idx = i[W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Latches rising edges on the request lines as pending events and offers
// them, highest index first, as binary codes over a valid/ready handshake.
module event_encoder
  import encoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         lost
);

  logic [N-1:0] req_q;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         lost_q, lost_d;
  state_e       state_q, state_d;

  logic [N-1:0] rise, cand, grant;
  logic [W-1:0] idx;
  logic         any, load;

  always_comb begin
    rise = req & ~req_q;
    cand = pending_q | rise;
  end

  prio_enc u_prio_enc (
    .in_vec (cand),
    .idx    (idx),
    .any    (any)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (any) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // Accepted slot is refilled in the same edge when work remains.
        if (ready) begin
          load    = any;
          state_d = any ? FULL : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    grant = '0;
    if (load) grant[idx] = 1'b1;

    code_d    = load ? idx : code_q;
    pending_d = cand & ~grant;
    lost_d    = |(rise & pending_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // Capturing req during reset keeps lines held high from looking like edges.
    if (!rst_n) begin
      req_q     <= req;
      state_q   <= EMPTY;
      code_q    <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      req_q     <= req;
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == FULL);
  assign pending = pending_q;
  assign lost    = lost_q;

endmodule
